map_job_sequencer: RTL
======================

// Module: map_job_sequencer
// PURPOSE
//  Job front/back end for the map9v3 LFSR mapping core. Queues N requests from a valid/ready
//  source and launches each one on the core with a clean start pulse. Detects completion on
//  the core's done output, captures dp, and returns it on a valid/ready response port.
//  Sits directly around the core: drives its N/start inputs and consumes its done/dp outputs.
// PARAMETERS
//  N_W        9     width of request value N and core N input
//  DP_W       9     width of core dp result
//  DEPTH      4     request FIFO entries (power of 2, >=2)
//  START_HOLD 2     cycles map_start is held high per launch (>=1)
//  GAP        2     min cycles map_start low between launches (>=2, re-arms core edge detect)
//  TO_CYC     1023  timeout in cycles, used only with MAP_SEQ_TIMEOUT_EN
// PORTS
//  clock      in   1     single clock, rising edge
//  reset      in   1     asynchronous, active-high; clears all state
//  req_valid  in   1     request present
//  req_ready  out  1     FIFO not full
//  req_n      in   N_W   N value for job
//  map_start  out  1     to core start
//  map_n      out  N_W   to core N; stable for the whole job
//  map_done   in   1     from core done
//  map_dp     in   DP_W  from core dp
//  rsp_valid  out  1     result available
//  rsp_ready  in   1     result accepted
//  rsp_dp     out  DP_W  captured dp
//  rsp_err    out  1     job timed out (0 without MAP_SEQ_TIMEOUT_EN)
//  busy       out  1     FSM not IDLE or FIFO non-empty
//  jobs_done  out  16    completed-response counter, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset values: req_ready=1, map_start=0, map_n=0, rsp_valid=0, rsp_dp=0, rsp_err=0, busy=0, jobs_done=0.
//  Request FIFO: push when req_valid&&req_ready; req_ready=!full (registered count); push at full ignored.
//   Push+pop same cycle on non-empty/non-full: count unchanged. Pop only in IDLE->LAUNCH.
//  done_q registers map_done each cycle; done_rise = map_done & ~done_q.
//  FSM (registered state):
//   IDLE:   FIFO non-empty -> pop head into map_n, hold_cnt=0, -> LAUNCH.
//   LAUNCH: map_start=1 for START_HOLD cycles, then -> WAIT.
//   WAIT:   map_start=0; on done_rise: rsp_dp<=map_dp, rsp_err<=0, rsp_valid<=1 -> RESP.
//           done_rise during LAUNCH is ignored (stale level from previous job).
//   RESP:   hold rsp_dp/rsp_err/rsp_valid until rsp_ready; on handshake rsp_valid<=0,
//           jobs_done+=1, gap_cnt=0 -> GAP.
//   GAP:    map_start=0 for GAP cycles -> IDLE.
//  Launch latency: request pushed into empty FIFO in IDLE -> map_start high 2 cycles later.
//  map_n changes only on pop; never while LAUNCH/WAIT/RESP.
//  Response latency: done_rise at cycle t -> rsp_valid at t+1.
//  rsp_ready asserted while rsp_valid=0: no effect.
//  Reset mid-job: map_start drops immediately, FIFO emptied, in-flight result discarded.
// CONFIGURATION
//  MAP_SEQ_TIMEOUT_EN defined: cycle counter runs in WAIT; reaching TO_CYC without done_rise ->
//   rsp_dp=0, rsp_err=1, rsp_valid=1, -> RESP (normal handshake, counts in jobs_done).
//  Not defined: no counter, WAIT waits indefinitely, rsp_err tied 0.
// STRUCTURE
//  Package map_seq_pkg: state enum {IDLE,LAUNCH,WAIT,RESP,GAP}, default widths N_W/DP_W,
//   jobs_done width constant.
//  Sub-module map_req_fifo (DEPTH x N_W, sync, full/empty/count) for the request queue.
//  FSM, edge detect, result capture, timeout in top level.
// TESTING
//  Bench pairs the block with a behavioural core model (done after programmable delay).
//  1 Single job: push N=0x0A5 -> map_n=0x0A5, map_start high exactly 2 cycles; model done
//    at +40 with dp=0x13C -> rsp_valid next cycle, rsp_dp=0x13C, jobs_done=1.
//  2 Backpressure/full: push 5 jobs back-to-back, DEPTH=4, no core completions ->
//    req_ready=0 after 4 queued + 1 popped; 6th push ignored; all 5 results in order.
//  3 Response stall: hold rsp_ready=0 for 20 cycles -> rsp_dp stable, no new map_start;
//    after accept, >=2 low cycles before next map_start.
//  4 Stale done: map_done left high from prior job during LAUNCH -> no response until
//    done falls and rises again.
//  5 Reset mid-WAIT: assert reset 3 cycles -> all outputs at reset values, queued jobs lost,
//    next push starts cleanly.
//  6 MAP_SEQ_TIMEOUT_EN, TO_CYC=16: no done -> rsp_err=1, rsp_dp=0 at WAIT+16; without
//    macro, same stimulus leaves rsp_valid=0 indefinitely.

Source files
------------

// File: rtl/map_seq_pkg.sv
// -----------------------------------------------------------------------------
// map_seq_pkg
//   Shared types and default widths for the map9v3 job sequencer.
//   - state_e     : sequencer FSM states
//   - MAP_N_W     : default width of the core N input / request value
//   - MAP_DP_W    : default width of the core dp result
//   - JOBS_W      : width of the completed-job counter
// -----------------------------------------------------------------------------
package map_seq_pkg;

    localparam int MAP_N_W  = 9;
    localparam int MAP_DP_W = 9;
    localparam int JOBS_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_RESP   = 3'd3,
        ST_GAP    = 3'd4
    } state_e;

    // Counter width for a count that runs 0..n-1 (never narrower than 1 bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/map_req_fifo.sv
// -----------------------------------------------------------------------------
// map_req_fifo
//   Synchronous request queue, DEPTH entries of W bits. Head is presented
//   combinationally on dout_o so the sequencer can latch it on the pop cycle.
//   Push when full and pop when empty are ignored.
// Ports
//   clock    in   rising-edge clock
//   reset    in   asynchronous active-high reset (pointers and count)
//   push_i   in   write din_i (ignored when full)
//   pop_i    in   drop head entry (ignored when empty)
//   din_i    in   W-bit write data
//   dout_o   out  W-bit head entry
//   full_o   out  count == DEPTH
//   empty_o  out  count == 0
//   count_o  out  number of stored entries
// -----------------------------------------------------------------------------
module map_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             din_i,
    output logic [W-1:0]             dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;

    logic do_push;
    logic do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage carries no reset; validity is tracked by the pointers/count.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din_i;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/map_job_sequencer.sv
// -----------------------------------------------------------------------------
// map_job_sequencer
//   Job front/back end for the map9v3 LFSR mapping core. Queues N requests,
//   launches each on the core with a START_HOLD-cycle start pulse, waits for a
//   rising edge on the core's done output, captures dp and returns it on a
//   valid/ready response port. A GAP-cycle low period on map_start between
//   launches re-arms the core's own start edge detector.
//
//   Optional feature macro: MAP_SEQ_TIMEOUT_EN
//     defined   : WAIT gives up after TO_CYC cycles and answers rsp_dp=0,
//                 rsp_err=1 through the normal response handshake.
//     undefined : WAIT waits forever, rsp_err is tied low.
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-high reset, clears all state
//   req_valid  in   request present
//   req_ready  out  request queue not full
//   req_n      in   N value for the job
//   map_start  out  core start (registered)
//   map_n      out  core N, stable for the whole job
//   map_done   in   core done level
//   map_dp     in   core dp result
//   rsp_valid  out  result available
//   rsp_ready  in   result accepted
//   rsp_dp     out  captured dp
//   rsp_err    out  job timed out
//   busy       out  FSM not idle or queue non-empty
//   jobs_done  out  completed-response counter (wraps)
// -----------------------------------------------------------------------------
module map_job_sequencer
    import map_seq_pkg::*;
#(
    parameter int N_W        = MAP_N_W,
    parameter int DP_W       = MAP_DP_W,
    parameter int DEPTH      = 4,
    parameter int START_HOLD = 2,
    parameter int GAP        = 2,
    parameter int TO_CYC     = 1023
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [N_W-1:0]    req_n,
    output logic              map_start,
    output logic [N_W-1:0]    map_n,
    input  logic              map_done,
    input  logic [DP_W-1:0]   map_dp,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DP_W-1:0]   rsp_dp,
    output logic              rsp_err,
    output logic              busy,
    output logic [JOBS_W-1:0] jobs_done
);

    // Elaboration-time parameter sanity checks.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two >= 2");
    end
    if (START_HOLD < 1) begin : g_bad_hold
        $error("START_HOLD must be >= 1");
    end
    if (GAP < 2) begin : g_bad_gap
        $error("GAP must be >= 2");
    end
    if (TO_CYC < 2) begin : g_bad_to
        $error("TO_CYC must be >= 2");
    end

    localparam int HOLD_W = cnt_width(START_HOLD);
    localparam int GAP_W  = cnt_width(GAP);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(START_HOLD - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP - 1);

    // ---------------------------------------------------------------- queue
    logic [N_W-1:0]           fifo_head;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [$clog2(DEPTH):0]   fifo_count;
    logic                     fifo_pop;

    state_e                   state_q;

    // The head is only consumed on the IDLE->LAUNCH transition.
    assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty;

    map_req_fifo #(
        .DEPTH (DEPTH),
        .W     (N_W)
    ) u_req_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (req_valid),
        .pop_i   (fifo_pop),
        .din_i   (req_n),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign req_ready = !fifo_full;

    // ------------------------------------------------------------ sequencer
    logic                map_start_q;
    logic [N_W-1:0]      map_n_q;
    logic                rsp_valid_q;
    logic [DP_W-1:0]     rsp_dp_q;
    logic [JOBS_W-1:0]   jobs_done_q;
    logic [HOLD_W-1:0]   hold_cnt_q;
    logic [GAP_W-1:0]    gap_cnt_q;
    logic                done_q;
    logic                done_rise;

`ifdef MAP_SEQ_TIMEOUT_EN
    localparam int TO_W = cnt_width(TO_CYC);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);
    logic [TO_W-1:0] to_cnt_q;
    logic            rsp_err_q;
`endif

    // A done level left high from a previous job produces no edge, so it can
    // never complete the current job.
    assign done_rise = map_done && !done_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            map_start_q <= 1'b0;
            map_n_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dp_q    <= '0;
            jobs_done_q <= '0;
            hold_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            done_q      <= 1'b0;
`ifdef MAP_SEQ_TIMEOUT_EN
            to_cnt_q    <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            done_q <= map_done;
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        map_n_q     <= fifo_head;
                        hold_cnt_q  <= '0;
                        map_start_q <= 1'b1;
                        state_q     <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    // Edges on done here belong to the previous job; ignored.
                    if (hold_cnt_q == HOLD_LAST) begin
                        map_start_q <= 1'b0;
                        state_q     <= ST_WAIT;
`ifdef MAP_SEQ_TIMEOUT_EN
                        to_cnt_q    <= '0;
`endif
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (done_rise) begin
                        rsp_dp_q    <= map_dp;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
`ifdef MAP_SEQ_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
                    end else if (to_cnt_q == TO_LAST) begin
                        rsp_dp_q    <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
`endif
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        jobs_done_q <= jobs_done_q + 1'b1;
                        gap_cnt_q   <= '0;
                        state_q     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    map_start_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign map_start = map_start_q;
    assign map_n     = map_n_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dp    = rsp_dp_q;
    assign jobs_done = jobs_done_q;
    assign busy      = (state_q != ST_IDLE) || (fifo_count != '0);

`ifdef MAP_SEQ_TIMEOUT_EN
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

endmodule
